serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder. It computes one sum bit per clock through a single
//  one-bit full-adder slice and keeps the carry in a register between bits.

---
 rtl/serial_pkg.sv | 12 +
 rtl/fa_bit.sv | 13 +
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder slice; purely combinational.
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one sum bit per clock through a single full-adder slice.
// Start accepted at edge T gives done in the cycle after edge T+WIDTH; next accept at T+WIDTH+2.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  fa_bit u_fa (
    .i_a  (r_op_a[0]),
    .i_b  (r_op_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // busy/done come straight from flops fed by the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DONE);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_op_a  <= a;
        r_op_b  <= b;
        r_carry <= cin;
        r_cnt   <= '0;
        r_sum   <= '0;
      end
    end else if (r_state == RUN) begin
      r_op_a  <= r_op_a >> 1;
      r_op_b  <= r_op_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      // cout only moves on the final bit so it holds through the run
      if (w_last) r_cout <= w_co;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8, 2 and 32 against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start2, start32;
  logic [7:0]  a8, b8;
  logic [1:0]  a2, b2;
  logic [31:0] a32, b32;
  logic        cin8, cin2, cin32;
  logic        busy8, done8, cout8;
  logic        busy2, done2, cout2;
  logic        busy32, done32, cout32;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [31:0] sum32;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_cout [3];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );
  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic c);
    case (w)
      2:       begin start2  = s; a2  = x[1:0]; b2  = y[1:0]; cin2  = c; end
      8:       begin start8  = s; a8  = x[7:0]; b8  = y[7:0]; cin8  = c; end
      default: begin start32 = s; a32 = x;      b32 = y;      cin32 = c; end
    endcase
  endtask

  task automatic sample(input int w, output logic ob, output logic od,
                        output logic [31:0] os, output logic oc);
    case (w)
      2:       begin ob = busy2;  od = done2;  os = {30'b0, sum2}; oc = cout2;  end
      8:       begin ob = busy8;  od = done8;  os = {24'b0, sum8}; oc = cout8;  end
      default: begin ob = busy32; od = done32; os = sum32;         oc = cout32; end
    endcase
  endtask

  // One operation; k counts edges after the accept edge T. done must appear
  // after edge T+w only, busy drops after edge T+w+1, and the caller may start
  // the next op immediately (accept at T+w+2). ign_at>0 pulses a zero start at T+ign_at.
  task automatic run_op(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input int ign_at, input string name);
    logic [31:0] mask;
    logic [32:0] full;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        ob, od, oc;
    logic [31:0] os;
    int          idx;
    idx  = (w == 2) ? 0 : (w == 8) ? 1 : 2;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, ta & mask} + {1'b0, tb_ & mask} + {32'b0, tc};
    exp_sum  = full[31:0] & mask;
    exp_cout = full[w];
    drive(w, 1'b1, ta, tb_, tc);
    tick();
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    for (int k = 1; k <= w + 1; k++) begin
      tick();
      sample(w, ob, od, os, oc);
      n_checks++;
      if (od !== (k == w)) begin
        n_fail++;
        $display("FAIL %s done w=%0d k=%0d: got %b expected %b", name, w, k, od, (k == w));
      end
      n_checks++;
      if (ob !== (k <= w)) begin
        n_fail++;
        $display("FAIL %s busy w=%0d k=%0d: got %b expected %b", name, w, k, ob, (k <= w));
      end
      if (k < w) begin
        n_checks++;
        if (oc !== prev_cout[idx]) begin
          n_fail++;
          $display("FAIL %s cout_hold w=%0d k=%0d: got %b expected %b", name, w, k, oc, prev_cout[idx]);
        end
      end else begin
        n_checks++;
        if (os !== exp_sum || oc !== exp_cout) begin
          n_fail++;
          $display("FAIL %s result w=%0d k=%0d: got cout=%b sum=%0h expected cout=%b sum=%0h",
                   name, w, k, oc, os, exp_cout, exp_sum);
        end
      end
      if (ign_at > 0 && k == ign_at - 1) drive(w, 1'b1, 32'd0, 32'd0, 1'b0);
      else drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    end
    prev_cout[idx] = exp_cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8, 1'b1, 32'h12, 32'h34, 1'b1);  // start during reset must lose
    drive(2, 1'b0, 0, 0, 1'b0);
    drive(32, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(8, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) prev_cout[i] = 1'b0;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%0h expected all 0", busy8, done8, cout8, sum8);
    end
    n_checks++;
    if ({busy2, done2, cout2, sum2} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset2: got busy=%b done=%b cout=%b sum=%0h expected all 0", busy2, done2, cout2, sum2);
    end
    n_checks++;
    if ({busy32, done32, cout32, sum32} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset32: got busy=%b done=%b cout=%b sum=%0h expected all 0", busy32, done32, cout32, sum32);
    end
    tick();
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_lost: got busy=%b expected 0", busy8);
    end
  endtask

  task automatic test_directed();
    run_op(8, 32'h0F, 32'h01, 1'b0, 0, "add_0f_01");
    run_op(8, 32'hFF, 32'h01, 1'b0, 0, "add_ff_01");
    run_op(8, 32'hFF, 32'h00, 1'b1, 0, "add_ff_00_c");
  endtask

  task automatic test_ignored_start();
    run_op(8, 32'hA5, 32'h5A, 1'b1, 3, "ignore_start");
  endtask

  task automatic test_mid_reset();
    drive(8, 1'b1, 32'h80, 32'h80, 1'b0);
    tick();
    drive(8, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;  // sampled at edge T+4
    tick();
    rst = 1'b0;
    prev_cout[1] = 1'b0;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b cout=%b sum=%0h expected all 0", busy8, done8, cout8, sum8);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet i=%0d: got done=%b busy=%b expected 0 0", i, done8, busy8);
      end
    end
    run_op(8, 32'h80, 32'h80, 1'b0, 0, "restart_80_80");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1000; i++)
      run_op(8, $urandom, $urandom, 1'($urandom), 0, "sweep8");
  endtask

  task automatic test_widths();
    run_op(2, 32'h3, 32'h1, 1'b0, 0, "w2_11_01");
    run_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, "w32_ones_1");
    for (int i = 0; i < 20; i++) begin
      run_op(2, $urandom, $urandom, 1'($urandom), 0, "sweep2");
      run_op(32, $urandom, $urandom, 1'($urandom), 0, "sweep32");
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(2, 1'b0, 0, 0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(32, 1'b0, 0, 0, 1'b0);
    test_reset();
    test_directed();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    test_widths();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
